// File: rtl/ai_traffic_controller.sv
// ai_traffic_controller: pool of AI car slots swept once per frame (update, spawn, publish); define AI_RANDOM_SPEED_EN for per-car random spawn speed
module ai_traffic_controller #(
   parameter int NUM_CARS       = 4,
   parameter int COORD_W        = 11,
   parameter int SCREEN_H       = 480,
   parameter int NUM_LANES      = 4,
   parameter int LANE_X0        = 192,
   parameter int LANE_W         = 64,
   parameter int CAR_W          = 64,
   parameter int CAR_H          = 64,
   parameter int BASE_SPEED     = 6,
   parameter int SPAWN_COOLDOWN = 40
) (
   input  logic                                    clk,
   input  logic                                    resetN,
   input  logic                                    frame_start,
   input  logic [COORD_W-1:0]                      random,
   input  logic [9:0]                              player_speed,
   input  logic [NUM_CARS-1:0]                     collision_hit,
   output logic [NUM_CARS-1:0][4:0][COORD_W-1:0]   car_state,
   output logic [NUM_CARS-1:0]                     active,
   output logic                                    busy
);
   localparam int IW = NUM_CARS > 1 ? $clog2(NUM_CARS) : 1;
   typedef enum logic [1:0] {IDLE, UPDATE, SPAWN, PUBLISH} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d, free_idx;
   logic [NUM_CARS-1:0][4:0][COORD_W-1:0] wrk_q, wrk_d;
   logic [NUM_CARS-1:0][COORD_W-1:0] spd_q, spd_d;
   logic [NUM_CARS-1:0] act_q, act_d, hit_q, hit_d;
   logic [COORD_W-1:0] cool_q, cool_d, cool_dec, lane, new_spd;
   logic [COORD_W:0] ny;
   logic has_free;
   assign busy     = state_q != IDLE;
   assign cool_dec = cool_q == '0 ? '0 : cool_q - 1'b1;
   assign lane     = random % COORD_W'(NUM_LANES);
   assign ny       = {1'b0, wrk_q[idx_q][2]} + (COORD_W+1)'(player_speed / 10'd32) - {1'b0, spd_q[idx_q]};
`ifdef AI_RANDOM_SPEED_EN
   assign new_spd  = COORD_W'(BASE_SPEED) + COORD_W'(random[1:0]);
`else
   assign new_spd  = COORD_W'(BASE_SPEED);
`endif
   // lowest-index free slot, using occupancy after this sweep's retirements
   always_comb begin
      has_free = 1'b0;
      free_idx = '0;
      for (int k = NUM_CARS - 1; k >= 0; k--) begin
         if (!act_q[k]) begin
            has_free = 1'b1;
            free_idx = IW'(k);
         end
      end
   end
   // sweep FSM: per-slot move/retire, then one spawn opportunity, then publish
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrk_d   = wrk_q;
      spd_d   = spd_q;
      act_d   = act_q;
      cool_d  = cool_q;
      hit_d   = hit_q | collision_hit;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = UPDATE;
               idx_d   = '0;
            end
         end
         UPDATE: begin
            if (act_q[idx_q]) begin
               if (hit_q[idx_q] || collision_hit[idx_q] || ny[COORD_W] || ny[COORD_W-1:0] >= COORD_W'(SCREEN_H)) begin
                  act_d[idx_q]    = 1'b0;
                  wrk_d[idx_q][4] = '0;
               end else begin
                  wrk_d[idx_q][2] = ny[COORD_W-1:0];
               end
            end
            hit_d[idx_q] = 1'b0;
            idx_d        = idx_q + 1'b1;
            state_d      = idx_q == IW'(NUM_CARS - 1) ? SPAWN : UPDATE;
         end
         SPAWN: begin
            cool_d = cool_dec;
            if (cool_dec == '0 && has_free) begin
               wrk_d[free_idx] = {COORD_W'(1) + COORD_W'(random[COORD_W-1]),
                                  COORD_W'(LANE_X0) + lane * COORD_W'(LANE_W),
                                  COORD_W'(0), COORD_W'(CAR_W), COORD_W'(CAR_H)};
               spd_d[free_idx] = new_spd;
               act_d[free_idx] = 1'b1;
               cool_d          = COORD_W'(SPAWN_COOLDOWN);
            end
            state_d = PUBLISH;
         end
         default: state_d = IDLE;
      endcase
   end
   // state registers; published outputs refresh only in PUBLISH so drawers see whole sweeps
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wrk_q     <= '0;
         spd_q     <= '0;
         act_q     <= '0;
         hit_q     <= '0;
         cool_q    <= '0;
         car_state <= '0;
         active    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wrk_q   <= wrk_d;
         spd_q   <= spd_d;
         act_q   <= act_d;
         hit_q   <= hit_d;
         cool_q  <= cool_d;
         if (state_q == PUBLISH) begin
            car_state <= wrk_q;
            active    <= act_q;
         end
      end
   end
endmodule

// File: tb/tb_ai_traffic_controller.sv
// tb_ai_traffic_controller: randomized frames against a per-frame car-pool model with a queued scoreboard
module tb_ai_traffic_controller;
   localparam int N  = 4;
   localparam int CW = 11;
   typedef struct packed {
      logic [N-1:0][4:0][CW-1:0] cs;
      logic [N-1:0]              act;
   } exp_t;
   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic frame_start = 1'b0;
   logic [CW-1:0] random = '0;
   logic [9:0] player_speed = '0;
   logic [N-1:0] collision_hit = '0;
   logic [N-1:0][4:0][CW-1:0] car_state;
   logic [N-1:0] active;
   logic busy;
   int nvec = 0;
   int nerr = 0;
   exp_t q[$];
   exp_t pub = '0;
   int my[N], mx[N], mimg[N], mspd[N];
   bit mact[N], mseen[N];
   int mcool;
   logic [N-1:0] mhit;
   ai_traffic_controller dut (
      .clk(clk), .resetN(resetN), .frame_start(frame_start), .random(random),
      .player_speed(player_speed), .collision_hit(collision_hit),
      .car_state(car_state), .active(active), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask
   task automatic model_reset();
      for (int s = 0; s < N; s++) begin
         my[s] = 0; mx[s] = 0; mimg[s] = 0; mspd[s] = 0; mact[s] = 0; mseen[s] = 0;
      end
      mcool = 0;
      mhit  = '0;
   endtask
   // one frame of game rules: move or retire every car, then maybe spawn one
   task automatic model_frame(int rnd, int ps, output exp_t e);
      int ny;
      bit done;
      for (int s = 0; s < N; s++) begin
         if (mact[s]) begin
            ny = my[s] + ps / 32 - mspd[s];
            if (mhit[s] || ny < 0 || ny >= 480) begin
               mact[s] = 0;
               mimg[s] = 0;
            end else my[s] = ny;
         end
      end
      mhit  = '0;
      mcool = mcool > 0 ? mcool - 1 : 0;
      done  = 0;
      for (int s = 0; s < N; s++) begin
         if (!done && mcool == 0 && !mact[s]) begin
            done     = 1;
            mact[s]  = 1;
            mseen[s] = 1;
            mx[s]    = 192 + 64 * (rnd % 4);
            my[s]    = 0;
            mimg[s]  = 1 + ((rnd >> 10) & 1);
`ifdef AI_RANDOM_SPEED_EN
            mspd[s]  = 6 + (rnd % 4);
`else
            mspd[s]  = 6;
`endif
            mcool    = 40;
         end
      end
      for (int s = 0; s < N; s++) begin
         e.cs[s][4] = CW'(mimg[s]);
         e.cs[s][3] = CW'(mx[s]);
         e.cs[s][2] = CW'(my[s]);
         e.cs[s][1] = mseen[s] ? CW'(64) : CW'(0);
         e.cs[s][0] = mseen[s] ? CW'(64) : CW'(0);
         e.act[s]   = mact[s];
      end
   endtask
   // monitor: outputs frozen while busy; on each sweep end check busy length and the published frame
   initial begin
      int bcnt = 0;
      logic pb = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!resetN) begin
            bcnt = 0;
            pb   = 1'b0;
            pub  = '0;
         end else begin
            if (busy) begin
               bcnt++;
               chk("hold_state", 256'(car_state), 256'(pub.cs));
               chk("hold_active", 256'(active), 256'(pub.act));
            end
            if (pb && !busy) begin
               chk("busy_len", 256'(bcnt), 256'(N + 2));
               if (q.size() == 0) begin
                  nerr++;
                  $display("FAIL scoreboard: sweep ended with no expected frame queued");
               end else begin
                  e = q.pop_front();
                  chk("car_state", 256'(car_state), 256'(e.cs));
                  chk("active", 256'(active), 256'(e.act));
                  pub = e;
               end
               bcnt = 0;
            end
            pb = busy;
         end
      end
   end
   task automatic do_reset();
      @(negedge clk);
      resetN = 1'b0;
      frame_start = 1'b0;
      collision_hit = '0;
      @(negedge clk);
      chk("rst_state", 256'(car_state), 256'(0));
      chk("rst_active", 256'(active), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      q.delete();
      model_reset();
      @(negedge clk);
      resetN = 1'b1;
   endtask
   task automatic frame(bit dbl, logic [N-1:0] hit);
      exp_t e;
      int c;
      @(negedge clk);
      collision_hit = hit;
      mhit |= hit;
      @(negedge clk);
      collision_hit = '0;
      frame_start = 1'b1;
      model_frame(int'(random), int'(player_speed), e);
      q.push_back(e);
      @(negedge clk);
      frame_start = 1'b0;
      if (dbl) begin
         @(negedge clk);
         frame_start = 1'b1;
         @(negedge clk);
         frame_start = 1'b0;
      end
      c = 0;
      while (busy && c < 40) begin
         @(negedge clk);
         c++;
      end
      if (c >= 40) begin
         nerr++;
         $display("FAIL sweep_timeout: busy still %b after %0d cycles", busy, c);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask
   initial begin
      model_reset();
      do_reset();
      random = 11'd2;
      player_speed = 10'd0;
      for (int f = 0; f < 40; f++) frame(f == 0, '0);
      player_speed = 10'd512;
      for (int f = 0; f < 60; f++) begin
         random = CW'($urandom_range(0, 2047));
         frame(f % 7 == 3, '0);
      end
      player_speed = 10'd192;
      for (int f = 0; f < 170; f++) begin
         random = CW'($urandom_range(0, 2047));
         frame(1'b0, '0);
      end
      random = CW'($urandom_range(0, 2047));
      frame(1'b0, 4'b0100);
      frame(1'b0, '0);
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      chk("busy_mid", 256'(busy), 256'(1));
      resetN = 1'b0;
      @(negedge clk);
      chk("midrst_state", 256'(car_state), 256'(0));
      chk("midrst_active", 256'(active), 256'(0));
      chk("midrst_busy", 256'(busy), 256'(0));
      q.delete();
      model_reset();
      @(negedge clk);
      resetN = 1'b1;
      for (int f = 0; f < 150; f++) begin
         random = CW'($urandom_range(0, 2047));
         player_speed = 10'($urandom_range(0, 1023));
         frame($urandom_range(0, 5) == 0, N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
